// File: rtl/mc_tag_scheduler_pkg.sv
// Shared definitions for the multicast tag scheduler: FSM encodings and
// packet geometry helpers.
package mc_tag_scheduler_pkg;

   // Sequencer states: idle after reset, programming unit tag IDs, dispatching packets.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PROG = 2'd1,
      ST_RUN  = 2'd2
   } sched_state_t;

   // A buffered packet is {tag, payload}.
   function automatic int packet_width(input int address_width, input int bitwidth);
      return address_width + bitwidth;
   endfunction

endpackage

// File: rtl/mc_tag_scheduler_if.sv
// Upstream packet handshake plus the shared multicast program/tag/value bus.
// The master side is the scheduler; the slave side is the environment
// (global buffer upstream, multicast controllers and PEs downstream).
interface mc_tag_scheduler_if #(
   parameter int NUM_UNITS     = 4,
   parameter int ADDRESS_WIDTH = 4,
   parameter int BITWIDTH      = 16
) ();

   logic                     in_valid;
   logic [ADDRESS_WIDTH-1:0] in_tag;
   logic [BITWIDTH-1:0]      in_value;
   logic                     in_ready;

   logic [NUM_UNITS-1:0]     mc_program;
   logic [ADDRESS_WIDTH-1:0] mc_tag_id;
   logic                     mc_enable;
   logic [ADDRESS_WIDTH-1:0] mc_tag;
   logic [BITWIDTH-1:0]      mc_value;
   logic [NUM_UNITS-1:0]     unit_ready;

   modport master (
      input  in_valid, in_tag, in_value, unit_ready,
      output in_ready, mc_program, mc_tag_id, mc_enable, mc_tag, mc_value
   );

   modport slave (
      output in_valid, in_tag, in_value, unit_ready,
      input  in_ready, mc_program, mc_tag_id, mc_enable, mc_tag, mc_value
   );

endinterface

// File: rtl/mc_tag_scheduler_sync_fifo.sv
// Single-clock FIFO with full/empty flags. Pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate count. Read data
// is the current head (no output register). Storage is not reset; only the
// pointers are, which is what discards buffered packets on reset.
module sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Advance read/write pointers on accepted push/pop.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Write the accepted entry into storage.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[PTR_W-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/mc_tag_scheduler.sv
// Sequencer for a row of multicast controllers sharing one tag/value bus.
// Programs each controller's tag ID, then buffers tagged packets and puts
// each one on the bus only once every matching unit is ready. Packets that
// match no unit are dropped and counted.
module mc_tag_scheduler
   import mc_tag_scheduler_pkg::*;
#(
   parameter int NUM_UNITS     = 4,
   parameter int ADDRESS_WIDTH = 4,
   parameter int BITWIDTH      = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int DROP_CNT_W    = 8
) (
   input  logic                               clk,
   input  logic                               rstb,
   input  logic                               cfg_start,
   input  logic [NUM_UNITS*ADDRESS_WIDTH-1:0] cfg_tag_ids,
   output logic                               cfg_done,
   mc_tag_scheduler_if.master                 bus,
   output logic [DROP_CNT_W-1:0]              drop_count,
   output logic                               busy
);

   localparam int PKT_W = packet_width(ADDRESS_WIDTH, BITWIDTH);
   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

   // Saturating increment for the drop counter.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // FSM and programming strobe registers
   sched_state_t             state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d, idx_inc;
   logic [NUM_UNITS-1:0]     prog_q, prog_d;
   logic [ADDRESS_WIDTH-1:0] tag_id_q, tag_id_d;
   logic                     done_q, done_d;
   logic                     cfg_take;

   // Shadow tag table: the tag ID each controller was programmed with.
   logic [ADDRESS_WIDTH-1:0] shadow [NUM_UNITS];

   // Packet buffer
   logic                     fifo_push;
   logic                     fifo_pop;
   logic [PKT_W-1:0]         fifo_wdata;
   logic [PKT_W-1:0]         fifo_rdata;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [ADDRESS_WIDTH-1:0] head_tag;
   logic [BITWIDTH-1:0]      head_value;

   // Dispatch decision
   logic [NUM_UNITS-1:0]     match;
   logic                     can_service;
   logic                     drop;
   logic                     go;
   logic                     in_ready_w;

   // Bus register and drop counter
   logic                     enable_q;
   logic [ADDRESS_WIDTH-1:0] mtag_q;
   logic [BITWIDTH-1:0]      mval_q;
   logic [DROP_CNT_W-1:0]    drop_q;

   assign idx_inc = idx_q + 1'b1;

   // Next-state logic and registered programming outputs.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      prog_d   = '0;
      tag_id_d = '0;
      done_d   = 1'b0;
      cfg_take = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) cfg_take = 1'b1;
         end
         ST_PROG: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_RUN;
            end else begin
               idx_d    = idx_inc;
               prog_d   = NUM_UNITS'(1) << idx_inc;
               tag_id_d = shadow[idx_inc];
               done_d   = (idx_inc == LAST_IDX);
            end
         end
         ST_RUN: begin
            // Reprogramming only once nothing is buffered or in flight on the bus.
            if (cfg_start && fifo_empty && !enable_q) cfg_take = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // First strobe comes straight from the config word, latched into the shadow table on the same edge.
      if (cfg_take) begin
         state_d  = ST_PROG;
         idx_d    = '0;
         prog_d   = NUM_UNITS'(1);
         tag_id_d = cfg_tag_ids[ADDRESS_WIDTH-1:0];
         done_d   = (NUM_UNITS == 1);
      end
   end

   // State register plus programming strobe, tag ID and done pulse.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         prog_q   <= '0;
         tag_id_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         prog_q   <= prog_d;
         tag_id_q <= tag_id_d;
         done_q   <= done_d;
      end
   end

   // Latch the requested tag IDs when programming starts.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < NUM_UNITS; i++) shadow[i] <= '0;
      end else if (cfg_take) begin
         for (int i = 0; i < NUM_UNITS; i++) shadow[i] <= cfg_tag_ids[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
   end

   // A full buffer refuses a push even when the head leaves in the same cycle.
   assign in_ready_w = (state_q == ST_RUN) && !fifo_full;
   assign fifo_push  = bus.in_valid & in_ready_w;
   assign fifo_wdata = {bus.in_tag, bus.in_value};

   sync_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_tag   = fifo_rdata[PKT_W-1 -: ADDRESS_WIDTH];
   assign head_value = fifo_rdata[BITWIDTH-1:0];

   // Which units the head packet targets.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_UNITS; i++) match[i] = (shadow[i] == head_tag);
   end

   // Drop unmatched heads; send matched heads only when all targets are ready; otherwise hold.
   assign can_service = (state_q == ST_RUN) && !fifo_empty;
   assign drop        = can_service && (match == '0);
   assign go          = can_service && (match != '0) && ((match & ~bus.unit_ready) == '0);
   assign fifo_pop    = drop | go;

   // Bus register: one-cycle enable per dispatch, tag/value hold while idle.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         enable_q <= 1'b0;
         mtag_q   <= '0;
         mval_q   <= '0;
      end else begin
         enable_q <= go;
         if (go) begin
            mtag_q <= head_tag;
            mval_q <= head_value;
         end
      end
   end

   // Count packets that matched no unit.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) drop_q <= '0;
      else if (drop) drop_q <= sat_inc(drop_q);
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.mc_program = prog_q;
   assign bus.mc_tag_id  = tag_id_q;
   assign bus.mc_enable  = enable_q;
   assign bus.mc_tag     = mtag_q;
   assign bus.mc_value   = mval_q;
   assign cfg_done       = done_q;
   assign drop_count     = drop_q;
   assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mc_tag_scheduler.sv
// Directed bench for mc_tag_scheduler: a per-cycle vector table for
// programming, dispatch, stall and drop, then hand-written sequences for
// counter saturation, buffer-full back-pressure and reset during programming.
module tb_mc_tag_scheduler;

   logic        clk;
   logic        rstb;
   logic        cfg_start;
   logic [15:0] cfg_tag_ids;
   logic        cfg_done;
   logic [7:0]  drop_count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   mc_tag_scheduler_if #(.NUM_UNITS(4), .ADDRESS_WIDTH(4), .BITWIDTH(16)) bus ();

   mc_tag_scheduler #(
      .NUM_UNITS     (4),
      .ADDRESS_WIDTH (4),
      .BITWIDTH      (16),
      .FIFO_DEPTH    (4),
      .DROP_CNT_W    (8)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .cfg_start   (cfg_start),
      .cfg_tag_ids (cfg_tag_ids),
      .cfg_done    (cfg_done),
      .bus         (bus),
      .drop_count  (drop_count),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        cs;
      logic        iv;
      logic [3:0]  tg;
      logic [15:0] vl;
      logic [3:0]  ur;
      logic [3:0]  e_prog;
      logic [3:0]  e_tid;
      logic        e_done;
      logic        e_ir;
      logic        e_en;
      logic [3:0]  e_tag;
      logic [15:0] e_val;
      logic [7:0]  e_drop;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic vec_t mkv(logic cs, logic iv, logic [3:0] tg, logic [15:0] vl, logic [3:0] ur,
                                logic [3:0] ep, logic [3:0] et, logic ed, logic eir, logic een,
                                logic [3:0] emt, logic [15:0] emv, logic [7:0] edr);
      vec_t r;
      r.cs = cs; r.iv = iv; r.tg = tg; r.vl = vl; r.ur = ur;
      r.e_prog = ep; r.e_tid = et; r.e_done = ed; r.e_ir = eir; r.e_en = een;
      r.e_tag = emt; r.e_val = emv; r.e_drop = edr;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one packet until accepted or the budget runs out.
   task automatic send(input logic [3:0] tag, input logic [15:0] val, output bit ok);
      int  budget;
      bit  acc;
      budget = 0;
      acc    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_tag   = tag;
      bus.in_value = val;
      do begin
         acc = bus.in_ready;
         tick();
         budget++;
      end while (!acc && budget < 50);
      bus.in_valid = 1'b0;
      ok = acc;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " mc_program"}, 32'(bus.mc_program), 0);
      check({tag, " mc_tag_id"},  32'(bus.mc_tag_id),  0);
      check({tag, " cfg_done"},   32'(cfg_done),       0);
      check({tag, " mc_enable"},  32'(bus.mc_enable),  0);
      check({tag, " mc_tag"},     32'(bus.mc_tag),     0);
      check({tag, " mc_value"},   32'(bus.mc_value),   0);
      check({tag, " in_ready"},   32'(bus.in_ready),   0);
      check({tag, " drop_count"}, 32'(drop_count),     0);
      check({tag, " busy"},       32'(busy),           0);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] got [$];
      logic [19:0] exp_pkt [5];
      bit          ok;
      bit          ok5;
      int          en_seen;

      // cycle: cs iv tag val ur | prog tid done in_ready en mtag mval drop
      vecs[0]  = mkv(1, 0, 0, 16'h0000, 4'hF, 4'h1, 0, 0, 0, 0, 0, 16'h0000, 0);
      vecs[1]  = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h2, 1, 0, 0, 0, 0, 16'h0000, 0);
      vecs[2]  = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h4, 2, 0, 0, 0, 0, 16'h0000, 0);
      vecs[3]  = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h8, 3, 1, 0, 0, 0, 16'h0000, 0);
      vecs[4]  = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 0, 0, 16'h0000, 0);
      vecs[5]  = mkv(0, 1, 2, 16'd512,  4'hF, 4'h0, 0, 0, 1, 0, 0, 16'h0000, 0);
      vecs[6]  = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 1, 2, 16'd512,  0);
      vecs[7]  = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 0, 2, 16'd512,  0);
      vecs[8]  = mkv(0, 1, 2, 16'h0AAA, 4'hB, 4'h0, 0, 0, 1, 0, 2, 16'd512,  0);
      vecs[9]  = mkv(0, 1, 0, 16'h0BBB, 4'hB, 4'h0, 0, 0, 1, 0, 2, 16'd512,  0);
      vecs[10] = mkv(0, 0, 0, 16'h0000, 4'hB, 4'h0, 0, 0, 1, 0, 2, 16'd512,  0);
      vecs[11] = mkv(0, 0, 0, 16'h0000, 4'hB, 4'h0, 0, 0, 1, 0, 2, 16'd512,  0);
      vecs[12] = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 1, 2, 16'h0AAA, 0);
      vecs[13] = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 1, 0, 16'h0BBB, 0);
      vecs[14] = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 0, 0, 16'h0BBB, 0);
      vecs[15] = mkv(0, 1, 9, 16'h1234, 4'hF, 4'h0, 0, 0, 1, 0, 0, 16'h0BBB, 0);
      vecs[16] = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 0, 0, 16'h0BBB, 1);
      vecs[17] = mkv(0, 0, 0, 16'h0000, 4'hF, 4'h0, 0, 0, 1, 0, 0, 16'h0BBB, 1);

      rstb           = 1'b0;
      cfg_start      = 1'b0;
      cfg_tag_ids    = 16'h3210;
      bus.in_valid   = 1'b0;
      bus.in_tag     = '0;
      bus.in_value   = '0;
      bus.unit_ready = 4'h0;

      repeat (3) tick();
      check_all_zero("reset");
      @(negedge clk);
      rstb = 1'b1;
      tick();

      // Programming, dispatch, head-of-line stall and drop, one row per cycle.
      for (int i = 0; i < NV; i++) begin
         cfg_start      = vecs[i].cs;
         bus.in_valid   = vecs[i].iv;
         bus.in_tag     = vecs[i].tg;
         bus.in_value   = vecs[i].vl;
         bus.unit_ready = vecs[i].ur;
         tick();
         check($sformatf("vec%0d mc_program", i), 32'(bus.mc_program), 32'(vecs[i].e_prog));
         check($sformatf("vec%0d mc_tag_id", i),  32'(bus.mc_tag_id),  32'(vecs[i].e_tid));
         check($sformatf("vec%0d cfg_done", i),   32'(cfg_done),       32'(vecs[i].e_done));
         check($sformatf("vec%0d in_ready", i),   32'(bus.in_ready),   32'(vecs[i].e_ir));
         check($sformatf("vec%0d mc_enable", i),  32'(bus.mc_enable),  32'(vecs[i].e_en));
         check($sformatf("vec%0d mc_tag", i),     32'(bus.mc_tag),     32'(vecs[i].e_tag));
         check($sformatf("vec%0d mc_value", i),   32'(bus.mc_value),   32'(vecs[i].e_val));
         check($sformatf("vec%0d drop_count", i), 32'(drop_count),     32'(vecs[i].e_drop));
      end
      cfg_start    = 1'b0;
      bus.in_valid = 1'b0;

      // Drop counter saturation: 254 more unmatched packets reach 255, further drops stay there.
      en_seen      = 0;
      bus.in_valid = 1'b1;
      bus.in_tag   = 4'd9;
      bus.in_value = 16'h5555;
      repeat (254) begin
         tick();
         if (bus.mc_enable) en_seen++;
      end
      bus.in_valid = 1'b0;
      tick();
      if (bus.mc_enable) en_seen++;
      check("drop reaches 255", 32'(drop_count), 255);
      bus.in_valid = 1'b1;
      repeat (5) begin
         tick();
         if (bus.mc_enable) en_seen++;
      end
      bus.in_valid = 1'b0;
      repeat (2) tick();
      check("drop saturates", 32'(drop_count), 255);
      check("no bus cycle for drops", 32'(en_seen), 0);

      // Buffer full: nothing ready, four accepted, fifth held upstream.
      bus.unit_ready = 4'h0;
      for (int k = 0; k < 4; k++) begin
         send(4'(k), 16'(100 + k), ok);
         check($sformatf("full push%0d accepted", k), 32'(ok), 1);
      end
      check("full in_ready low", 32'(bus.in_ready), 0);
      bus.in_valid = 1'b1;
      bus.in_tag   = 4'd0;
      bus.in_value = 16'd104;
      repeat (2) tick();
      check("full in_ready still low", 32'(bus.in_ready), 0);
      check("full no dispatch", 32'(bus.mc_enable), 0);
      check("full busy", 32'(busy), 1);

      ok5 = 1'b0;
      fork
         begin
            bus.unit_ready = 4'hF;
            send(4'd0, 16'd104, ok5);
         end
         begin
            repeat (20) begin
               tick();
               if (bus.mc_enable) got.push_back({bus.mc_tag, bus.mc_value});
            end
         end
      join
      check("full fifth accepted", 32'(ok5), 1);
      exp_pkt[0] = {4'd0, 16'd100};
      exp_pkt[1] = {4'd1, 16'd101};
      exp_pkt[2] = {4'd2, 16'd102};
      exp_pkt[3] = {4'd3, 16'd103};
      exp_pkt[4] = {4'd0, 16'd104};
      check("full dispatch count", 32'(got.size()), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < got.size()) check($sformatf("full dispatch%0d", k), 32'(got[k]), 32'(exp_pkt[k]));
         else                check($sformatf("full dispatch%0d missing", k), 32'hDEAD, 32'(exp_pkt[k]));
      end
      check("idle after drain busy", 32'(busy), 1);

      // Reprogram from RUN, then reset after two strobes.
      cfg_tag_ids = 16'h0123;
      cfg_start   = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("reprog strobe0", 32'(bus.mc_program), 32'h1);
      check("reprog tag_id0", 32'(bus.mc_tag_id), 3);
      tick();
      check("reprog strobe1", 32'(bus.mc_program), 32'h2);
      check("reprog tag_id1", 32'(bus.mc_tag_id), 2);
      #2 rstb = 1'b0;
      #1;
      check_all_zero("midprog reset");
      #2 rstb = 1'b1;
      repeat (2) tick();
      check("post reset idle busy", 32'(busy), 0);
      check("post reset no strobe", 32'(bus.mc_program), 0);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("restart strobe0", 32'(bus.mc_program), 32'h1);
      check("restart tag_id0", 32'(bus.mc_tag_id), 3);
      tick();
      check("restart strobe1", 32'(bus.mc_program), 32'h2);
      check("restart tag_id1", 32'(bus.mc_tag_id), 2);
      check("restart in_ready low", 32'(bus.in_ready), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
